// File: rtl/fifo_drain_if.sv
// Bundle of FIFO read-side and downstream stream signals for fifo_drain.
// The slave modport is the drain itself; master is the environment around it.
interface fifo_drain_if #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  logic              en;
  logic              empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic [CNT_W-1:0]  rd_cnt;
  logic [OCC_W-1:0]  occ;

  modport master (
    output en, empty, rd_data, ready_i,
    input  rd_en, data_o, valid_o, rd_cnt, occ
  );

  modport slave (
    input  en, empty, rd_data, ready_i,
    output rd_en, data_o, valid_o, rd_cnt, occ
  );
endinterface

// File: rtl/fifo_drain.sv
// Read-side consumer for the async FIFO: issues rd_en, captures the one-cycle-late
// read data into a circular skid buffer and streams it out on valid/ready.
module fifo_drain #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic       clk_r,
  input  logic       reset,
  fifo_drain_if.slave bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dataO;

  logic              w_rdEn;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rdPtrNext;
  logic [PTR_W-1:0]  w_wrPtrNext;

  // Reserve a slot for the word already in flight so a push never finds the buffer full.
  assign w_rdEn  = bus.en && !bus.empty && !reset &&
                   ((int'(r_occ) + int'(r_inflight)) < BUF_DEPTH);
  assign w_valid = (r_occ != '0);
  assign w_push  = r_inflight;
  assign w_pop   = w_valid && bus.ready_i;

  assign w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
  assign w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);

  always_ff @(posedge clk_r) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_dataO    <= '0;
    end else begin
      r_inflight <= w_rdEn;
      r_occ      <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      if (w_push) begin
        r_mem[r_wrPtr] <= bus.rd_data;
        r_wrPtr        <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // data_o tracks the entry that will be at the head after this edge.
      if (w_pop) begin
        if (r_occ >= OCC_W'(2))
          r_dataO <= r_mem[w_rdPtrNext];
        else if (w_push)
          r_dataO <= bus.rd_data;
      end else if (!w_valid && w_push) begin
        r_dataO <= bus.rd_data;
      end
    end
  end

  assign bus.rd_en   = w_rdEn;
  assign bus.valid_o = w_valid;
  assign bus.data_o  = r_dataO;
  assign bus.rd_cnt  = r_cnt;
  assign bus.occ     = r_occ;
endmodule

// File: tb/tb_fifo_drain.sv
// Randomized bench for fifo_drain: a queue-based FIFO and skid-buffer model
// predicts every output each cycle; a second instance with CNT_W=4 checks wrap.
module tb_fifo_drain;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = 16;

  logic clk_r = 1'b0;
  logic reset = 1'b1;

  always #5 clk_r = ~clk_r;

  fifo_drain_if #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) bus ();
  fifo_drain_if #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(4))     bus4 ();

  assign bus4.en      = bus.en;
  assign bus4.empty   = bus.empty;
  assign bus4.rd_data = bus.rd_data;
  assign bus4.ready_i = bus.ready_i;

  fifo_drain #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk_r (clk_r),
    .reset (reset),
    .bus   (bus.slave)
  );

  fifo_drain #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(4)) u_dut4 (
    .clk_r (clk_r),
    .reset (reset),
    .bus   (bus4.slave)
  );

  logic [DATA_W-1:0] srcQ[$];
  logic [DATA_W-1:0] bufQ[$];
  bit                mInflight;
  logic [DATA_W-1:0] mInflightWord;
  int unsigned       mCnt;
  int                testsRun;
  int                testsFailed;
  int                rdEnSeen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs at the falling edge, then advance the model.
  task automatic applyStimulus(input bit rstIn, input bit enIn, input bit readyIn,
                               input bit holdEmpty);
    bit expRdEn;
    bit pop;
    reset       = rstIn;
    bus.en      = enIn;
    bus.ready_i = readyIn;
    bus.empty   = holdEmpty || (srcQ.size() == 0);
    bus.rd_data = mInflight ? mInflightWord : DATA_W'($urandom);
    @(negedge clk_r);
    expRdEn = enIn && !bus.empty && !rstIn && ((bufQ.size() + int'(mInflight)) < BUF_DEPTH);
    checkOutput("rd_en", 32'(bus.rd_en), 32'(expRdEn));
    checkOutput("valid_o", 32'(bus.valid_o), 32'(bufQ.size() != 0));
    checkOutput("occ", 32'(bus.occ), 32'(bufQ.size()));
    checkOutput("occ_bound", 32'(int'(bus.occ) <= BUF_DEPTH), 32'd1);
    if (bufQ.size() != 0) checkOutput("data_o", 32'(bus.data_o), 32'(bufQ[0]));
    checkOutput("rd_cnt", 32'(bus.rd_cnt), mCnt & 32'hFFFF);
    checkOutput("rd_cnt_w4", 32'(bus4.rd_cnt), mCnt & 32'hF);
    if (bus.empty) checkOutput("rd_en_while_empty", 32'(bus.rd_en), 32'd0);
    rdEnSeen += int'(bus.rd_en);
    pop = (bufQ.size() != 0) && readyIn;
    if (rstIn) begin
      bufQ.delete();
      mInflight = 1'b0;
      mCnt      = 0;
    end else begin
      if (pop) begin
        void'(bufQ.pop_front());
        mCnt++;
      end
      if (mInflight) bufQ.push_back(mInflightWord);
      mInflight = expRdEn;
      if (expRdEn) mInflightWord = srcQ.pop_front();
    end
    @(posedge clk_r);
    #1;
  endtask

  task automatic drainAll(input int budget);
    int cycles = 0;
    while ((srcQ.size() != 0 || bufQ.size() != 0 || mInflight) && cycles < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      cycles++;
    end
    checkOutput("drain_done", 32'(srcQ.size() + bufQ.size() + int'(mInflight)), 32'd0);
  endtask

  initial begin
    int cycles;
    bus.en      = 1'b1;
    bus.empty   = 1'b0;
    bus.ready_i = 1'b0;
    bus.rd_data = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk_r);
    #1;

    // Reset held with data available and en=1, then three-word burst.
    srcQ = '{8'h11, 8'h22, 8'h33};
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("burst_cnt", 32'(bus.rd_cnt), 32'd3);

    // Backpressure: only BUF_DEPTH reads may be outstanding.
    for (int i = 0; i < 20; i++) srcQ.push_back(DATA_W'(8'h40 + i));
    rdEnSeen = 0;
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_pulses", 32'(rdEnSeen), 32'd4);
    checkOutput("bp_occ", 32'(bus.occ), 32'd4);
    checkOutput("bp_head", 32'(bus.data_o), 32'h40);
    drainAll(100);
    checkOutput("bp_delivered", 32'(bus.rd_cnt), 32'd23);
    checkOutput("cnt4_wrap", 32'(bus4.rd_cnt), 32'd7);

    // en dropped right after one read: in-flight word still lands.
    srcQ = '{8'hA0, 8'hA1, 8'hA2};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    rdEnSeen = 0;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("en_off_pulses", 32'(rdEnSeen), 32'd0);
    checkOutput("en_off_occ", 32'(bus.occ), 32'd1);
    checkOutput("en_off_head", 32'(bus.data_o), 32'hA0);
    drainAll(50);

    // Random backpressure, empty toggling and occasional en drops.
    for (int i = 0; i < 1000; i++) srcQ.push_back(DATA_W'($urandom));
    cycles = 0;
    while ((srcQ.size() != 0 || bufQ.size() != 0 || mInflight) && cycles < 20000) begin
      applyStimulus(1'b0, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0);
      cycles++;
    end
    checkOutput("random_done", 32'(srcQ.size() + bufQ.size() + int'(mInflight)), 32'd0);
    checkOutput("random_cnt", 32'(bus.rd_cnt), 32'(1026 & 32'hFFFF));

    // Reset mid-operation with two buffered words and one in flight.
    for (int i = 0; i < 10; i++) srcQ.push_back(DATA_W'(8'hC0 + i));
    cycles = 0;
    while (!(bufQ.size() == 2 && mInflight) && cycles < 20) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      cycles++;
    end
    checkOutput("pre_reset_occ", 32'(bus.occ), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_occ", 32'(bus.occ), 32'd0);
    checkOutput("post_reset_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("post_reset_cnt", 32'(bus.rd_cnt), 32'd0);
    drainAll(100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
